music_sequencer: RTL and testbench



---
 rtl/music_sequencer_pkg.sv | 38 +++
 rtl/music_sequencer_rom.sv | 56 +++++
 rtl/music_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// music_sequencer_pkg
// Shared definitions for the music sequencer:
//   - seq_state_e : sequencer FSM states
//   - SILENCE     : tone value meaning "no note" (outside the audible range)
//   - C4..B4      : octave-4 note frequencies in Hz (F4 is natural-4, FS4 sharp-4)
//   - oct_up/oct_dn : shift a frequency one octave up/down
// No ports (package).
// -----------------------------------------------------------------------------
package music_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    localparam int SILENCE = 20000;

    localparam int C4  = 261;
    localparam int D4  = 293;
    localparam int E4  = 329;
    localparam int F4  = 349;
    localparam int FS4 = 370;
    localparam int G4  = 392;
    localparam int A4  = 440;
    localparam int B4  = 493;

    function automatic int oct_up(input int f);
        return f * 2;
    endfunction

    function automatic int oct_dn(input int f);
        return f / 2;
    endfunction

endpackage

// File: rtl/music_sequencer_rom.sv
// -----------------------------------------------------------------------------
// music_note_rom
// Combinational per-channel note table.
//   channel : channel index (0 = melody, 1 = bass, others silent)
//   beat    : quarter-beat index
//   tone    : note frequency in Hz, SILENCE past the end of the song
// -----------------------------------------------------------------------------
module music_note_rom
    import music_sequencer_pkg::*;
#(
    parameter int SONG_LEN = 72,
    parameter int BEAT_W   = 8,
    parameter int TONE_W   = 32,
    parameter int CH_W     = 1
) (
    input  logic [CH_W-1:0]   channel,
    input  logic [BEAT_W-1:0] beat,
    output logic [TONE_W-1:0] tone
);

    int w_beat;
    int w_freq;

    assign w_beat = int'(beat);

    always_comb begin
        w_freq = SILENCE;
        if (w_beat < SONG_LEN) begin
            if (channel == CH_W'(0)) begin
                // Melody: ascending C major scale, one note per quarter-beat
                case (w_beat % 8)
                    0:       w_freq = C4;
                    1:       w_freq = D4;
                    2:       w_freq = E4;
                    3:       w_freq = F4;
                    4:       w_freq = G4;
                    5:       w_freq = A4;
                    6:       w_freq = B4;
                    7:       w_freq = oct_up(C4);
                    default: w_freq = SILENCE;
                endcase
            end else if (channel == CH_W'(1)) begin
                // Bass: I-IV-V-I one octave down, one chord per four quarter-beats
                case ((w_beat / 4) % 4)
                    0:       w_freq = oct_dn(C4);
                    1:       w_freq = oct_dn(F4);
                    2:       w_freq = oct_dn(G4);
                    default: w_freq = oct_dn(C4);
                endcase
            end
        end
    end

    assign tone = TONE_W'(w_freq);

endmodule

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
// Plays a fixed song from a note table, one table entry per quarter-beat.
//   clk       : rising-edge system clock
//   rst_n     : asynchronous active-low reset
//   start     : pulse, (re)start from beat 0
//   stop      : pulse, abort to idle (wins over start)
//   pause     : level, hold position while high
//   loop_en   : level, wrap to beat 0 at song end
//   tempo_sel : beat period = (CLK_HZ/BEAT_HZ) >> tempo_sel clocks (min 1)
//   tone      : registered per-channel tone, channel k at [k*TONE_W +: TONE_W]
//   beat_num  : current beat index
//   beat_tick : pulse on each beat advance
//   busy      : high in PLAY or PAUSE
//   done      : pulse when the last beat completes
// -----------------------------------------------------------------------------
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int BEAT_HZ  = 8,
    parameter int SONG_LEN = 72,
    parameter int BEAT_W   = 8,
    parameter int TONE_W   = 32,
    parameter int N_CH     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   loop_en,
    input  logic [1:0]             tempo_sel,
    output logic [N_CH*TONE_W-1:0] tone,
    output logic [BEAT_W-1:0]      beat_num,
    output logic                   beat_tick,
    output logic                   busy,
    output logic                   done
);

    localparam int BASE_DIV = (CLK_HZ / BEAT_HZ < 1) ? 1 : CLK_HZ / BEAT_HZ;
    localparam int CNT_W    = $clog2(BASE_DIV + 1);
    localparam int CH_W     = (N_CH < 2) ? 1 : $clog2(N_CH);

    localparam logic [CNT_W-1:0]  BASE_DIV_C = CNT_W'(BASE_DIV);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(SONG_LEN - 1);
    localparam logic [TONE_W-1:0] SILENCE_T  = TONE_W'(SILENCE);

    seq_state_e               r_state;
    seq_state_e               w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_div;
    logic [CNT_W-1:0]         w_div_new;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_tick;
    logic                     r_done;
    logic [N_CH*TONE_W-1:0]   r_tone;
    logic [N_CH*TONE_W-1:0]   w_rom_tone;
    logic                     w_run;
    logic                     w_adv;
    logic                     w_last;

    // Period for the next beat; only latched on restart or prescaler wrap
    always_comb begin
        w_div_new = BASE_DIV_C >> tempo_sel;
        if (w_div_new == '0) begin
            w_div_new = CNT_W'(1);
        end
    end

    // Counting happens only in PLAY with pause low and no start/stop override
    assign w_run  = (r_state == S_PLAY) && !pause && !start && !stop;
    assign w_adv  = w_run && (r_cnt == r_div - CNT_W'(1));
    assign w_last = (r_beat == LAST_BEAT);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state (stop > start > pause > beat advance)
    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_adv && w_last && !loop_en) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state == S_PLAY) || (r_state == S_PAUSE);
    end

    // Prescaler, beat position and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_div  <= BASE_DIV_C;
            r_beat <= '0;
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= w_adv;
            r_done <= w_adv && w_last;
            if (stop) begin
                r_cnt  <= '0;
                r_beat <= '0;
            end else if (start) begin
                r_cnt  <= '0;
                r_beat <= '0;
                r_div  <= w_div_new;
            end else if (w_run) begin
                if (w_adv) begin
                    r_cnt <= '0;
                    r_div <= w_div_new;
                    if (w_last) begin
                        // Without looping the last beat index is held in DONE
                        r_beat <= loop_en ? '0 : r_beat;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        music_note_rom #(
            .SONG_LEN (SONG_LEN),
            .BEAT_W   (BEAT_W),
            .TONE_W   (TONE_W),
            .CH_W     (CH_W)
        ) u_rom (
            .channel (CH_W'(k)),
            .beat    (r_beat),
            .tone    (w_rom_tone[k*TONE_W +: TONE_W])
        );
    end

    // Tone follows beat_num with one cycle of latency; silent unless playing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone <= {N_CH{SILENCE_T}};
        end else if (r_state == S_PLAY) begin
            r_tone <= w_rom_tone;
        end else begin
            r_tone <= {N_CH{SILENCE_T}};
        end
    end

    assign tone      = r_tone;
    assign beat_num  = r_beat;
    assign beat_tick = r_tick;
    assign done      = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
module tb_music_sequencer;

    localparam int TONE_W = 32;
    localparam int N_CH   = 2;
    localparam int BEAT_W = 8;
    localparam int SIL    = 20000;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic                   pause = 1'b0;
    logic                   loop_en = 1'b0;
    logic [1:0]             tempo_sel = 2'd0;
    logic [N_CH*TONE_W-1:0] tone;
    logic [BEAT_W-1:0]      beat_num;
    logic                   beat_tick;
    logic                   busy;
    logic                   done;

    int n_run  = 0;
    int n_fail = 0;

    music_sequencer #(
        .CLK_HZ   (16),
        .BEAT_HZ  (4),
        .SONG_LEN (4),
        .BEAT_W   (BEAT_W),
        .TONE_W   (TONE_W),
        .N_CH     (N_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .tone      (tone),
        .beat_num  (beat_num),
        .beat_tick (beat_tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       loop_en;
        logic [1:0] tsel;
        int         beat;
        logic       tick;
        logic       done;
        logic       busy;
        int         ch0;
        int         ch1;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] tone_of(input int c0, input int c1);
        logic [31:0] a;
        logic [31:0] b;
        a = 32'(c0);
        b = 32'(c1);
        return {b, a};
    endfunction

    function automatic void add(input logic st, input logic sp, input logic pa, input logic lp,
                                input int eb, input logic et, input logic ed, input logic eby,
                                input int c0, input int c1);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = pa; v.loop_en = lp; v.tsel = 2'd0;
        v.beat = eb; v.tick = et; v.done = ed; v.busy = eby; v.ch0 = c0; v.ch1 = c1;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int eb, input logic et, input logic ed,
                           input logic eby, input int c0, input int c1);
        chk({nm, " beat_num"}, 64'(beat_num), 64'(eb));
        chk({nm, " beat_tick"}, 64'(beat_tick), 64'(et));
        chk({nm, " done"}, 64'(done), 64'(ed));
        chk({nm, " busy"}, 64'(busy), 64'(eby));
        chk({nm, " tone"}, 64'(tone), tone_of(c0, c1));
    endtask

    initial begin
        int ticks;
        int dones;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, SIL, SIL);
        #19 rst_n = 1'b1;

        // Basic song, then start/pause priority, then stop
        add(1, 0, 0, 0, 0, 0, 0, 1, SIL, SIL);   // E0 start
        add(0, 0, 0, 0, 0, 0, 0, 1, 261, 130);
        add(0, 0, 0, 0, 0, 0, 0, 1, 261, 130);
        add(0, 0, 0, 0, 0, 0, 0, 1, 261, 130);
        add(0, 0, 0, 0, 1, 1, 0, 1, 261, 130);   // E4 first tick
        add(0, 0, 0, 0, 1, 0, 0, 1, 293, 130);
        add(0, 0, 0, 0, 1, 0, 0, 1, 293, 130);
        add(0, 0, 0, 0, 1, 0, 0, 1, 293, 130);
        add(0, 0, 0, 0, 2, 1, 0, 1, 293, 130);   // E8
        add(0, 0, 0, 0, 2, 0, 0, 1, 329, 130);
        add(0, 0, 0, 0, 2, 0, 0, 1, 329, 130);
        add(0, 0, 0, 0, 2, 0, 0, 1, 329, 130);
        add(0, 0, 0, 0, 3, 1, 0, 1, 329, 130);   // E12
        add(0, 0, 0, 0, 3, 0, 0, 1, 349, 130);
        add(0, 0, 0, 0, 3, 0, 0, 1, 349, 130);
        add(0, 0, 0, 0, 3, 0, 0, 1, 349, 130);
        add(0, 0, 0, 0, 3, 1, 1, 0, 349, 130);   // E16 done, DONE state
        add(0, 0, 0, 0, 3, 0, 0, 0, SIL, SIL);
        add(1, 0, 0, 0, 0, 0, 0, 1, SIL, SIL);   // restart from DONE
        add(0, 0, 1, 0, 0, 0, 0, 1, 261, 130);   // -> PAUSE
        add(0, 0, 1, 0, 0, 0, 0, 1, SIL, SIL);
        add(1, 0, 1, 0, 0, 0, 0, 1, SIL, SIL);   // start beats pause -> PLAY
        add(0, 0, 0, 0, 0, 0, 0, 1, 261, 130);   // PLAY shows a note
        add(0, 1, 0, 0, 0, 0, 0, 0, 261, 130);   // stop
        add(0, 0, 0, 0, 0, 0, 0, 0, SIL, SIL);

        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            pause     = vecs[i].pause;
            loop_en   = vecs[i].loop_en;
            tempo_sel = vecs[i].tsel;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].beat, vecs[i].tick, vecs[i].done,
                    vecs[i].busy, vecs[i].ch0, vecs[i].ch1);
        end
        start = 0; stop = 0; pause = 0; loop_en = 0; tempo_sel = 0;

        // Looping: two laps, one done per lap
        loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        ticks = 0;
        dones = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            ticks += int'(beat_tick);
            dones += int'(done);
            if (k == 16 || k == 32) begin
                chk($sformatf("loop lap%0d beat_num", k / 16), 64'(beat_num), 64'd0);
                chk($sformatf("loop lap%0d busy", k / 16), 64'(busy), 64'd1);
                chk($sformatf("loop lap%0d done", k / 16), 64'(done), 64'd1);
            end
        end
        chk("loop tick count", 64'(ticks), 64'd8);
        chk("loop done count", 64'(dones), 64'd2);
        loop_en = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;

        // Pause two clocks into beat 1 for ten clocks
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        chk("pause pre beat_num", 64'(beat_num), 64'd1);
        repeat (2) step();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("pause%0d beat_num", k), 64'(beat_num), 64'd1);
            chk($sformatf("pause%0d busy", k), 64'(busy), 64'd1);
            chk($sformatf("pause%0d beat_tick", k), 64'(beat_tick), 64'd0);
            if (k >= 1) chk($sformatf("pause%0d tone", k), 64'(tone), tone_of(SIL, SIL));
        end
        pause = 1'b0;
        step(); chk("resume+0 beat_tick", 64'(beat_tick), 64'd0);
        step(); chk("resume+1 beat_tick", 64'(beat_tick), 64'd0);
        step(); chk("resume+2 beat_tick", 64'(beat_tick), 64'd1);
        chk("resume+2 beat_num", 64'(beat_num), 64'd2);
        stop = 1'b1; step(); stop = 1'b0;

        // tempo_sel=2: one-clock beats
        tempo_sel = 2'd2;
        start = 1'b1; step(); start = 1'b0;
        chk("fast E0 beat_tick", 64'(beat_tick), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("fast E%0d beat_tick", k), 64'(beat_tick), 64'd1);
            chk($sformatf("fast E%0d beat_num", k), 64'(beat_num), 64'((k == 4) ? 3 : k));
            chk($sformatf("fast E%0d done", k), 64'(done), 64'(k == 4));
            chk($sformatf("fast E%0d busy", k), 64'(busy), 64'(k != 4));
        end

        // Tempo change mid-beat applies after the next tick
        tempo_sel = 2'd0;
        start = 1'b1; step(); start = 1'b0;
        step();
        tempo_sel = 2'd1;
        step(); chk("tchg E2 beat_tick", 64'(beat_tick), 64'd0);
        step(); chk("tchg E3 beat_tick", 64'(beat_tick), 64'd0);
        step(); chk("tchg E4 beat_tick", 64'(beat_tick), 64'd1);
        chk("tchg E4 beat_num", 64'(beat_num), 64'd1);
        step(); chk("tchg E5 beat_tick", 64'(beat_tick), 64'd0);
        step(); chk("tchg E6 beat_tick", 64'(beat_tick), 64'd1);
        chk("tchg E6 beat_num", 64'(beat_num), 64'd2);

        // start and stop together while playing: stop wins
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("startstop busy", 64'(busy), 64'd0);
        chk("startstop beat_num", 64'(beat_num), 64'd0);
        step();
        chk("startstop idle busy", 64'(busy), 64'd0);
        chk("startstop idle tone", 64'(tone), tone_of(SIL, SIL));

        // Asynchronous reset at beat 2
        tempo_sel = 2'd0;
        start = 1'b1; step(); start = 1'b0;
        repeat (8) step();
        chk("prerst beat_num", 64'(beat_num), 64'd2);
        chk("prerst beat_tick", 64'(beat_tick), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 1'b0, 1'b0, 1'b0, SIL, SIL);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        chk_all("post rst idle", 0, 1'b0, 1'b0, 1'b0, SIL, SIL);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
